// File: rtl/mem_pipe_ctrl.sv
// Main-memory controller behind the I/D-cache arbiter: fixed-latency, fully pipelined word access.
// Latency: LATENCY cycles from acceptance to the one-cycle rspValid strobe; one request per cycle.
// Backpressure: memReady is low in reset (and in refresh cycles when built with MEM_REFRESH_EN); the requester holds its request.
//
// Optional feature macro: MEM_REFRESH_EN (adds REFRESH_PERIOD and periodic 2-cycle refresh windows).
//
// Ports:
//   clk, rst_n                              clock, async active-low reset
//   memEnable, memWrite, reqSrc             request valid, write flag, requester id (0 = ICache, 1 = DCache)
//   addrToMem, dataToMem                    request word address and write data
//   memReady                                request can be accepted this cycle
//   rspValid, rspWrite, rspSrc, rspAddr     response strobe and the request's write flag, id and full address
//   dataFromMem                             read data, or echoed write data for a write acknowledge
module mem_pipe_ctrl #(
    parameter int ADDR_W         = 16,
    parameter int DATA_W         = 16,
    parameter int MEM_WORDS      = 1024,
    parameter int LATENCY        = 4
`ifdef MEM_REFRESH_EN
    ,
    parameter int REFRESH_PERIOD = 64
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              memEnable,
    input  logic              memWrite,
    input  logic              reqSrc,
    input  logic [ADDR_W-1:0] addrToMem,
    input  logic [DATA_W-1:0] dataToMem,
    output logic              memReady,
    output logic              rspValid,
    output logic              rspWrite,
    output logic              rspSrc,
    output logic [ADDR_W-1:0] rspAddr,
    output logic [DATA_W-1:0] dataFromMem
);

    localparam int IDX_W = $clog2(MEM_WORDS);
    // The output register is the last stage, so LATENCY-1 shift stages sit in front of it.
    localparam int DEPTH = (LATENCY > 1) ? LATENCY - 1 : 1;

    typedef struct packed {
        logic              vld;
        logic              wr;
        logic              src;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] dat;
    } stage_t;

    stage_t in_stage;
    stage_t ret_stage;
    stage_t pipe_q [DEPTH];
    stage_t pipe_d [DEPTH];

    logic              ready_q;
    logic              rsp_vld_q, rsp_vld_d;
    logic              rsp_wr_q,  rsp_wr_d;
    logic              rsp_src_q, rsp_src_d;
    logic [ADDR_W-1:0] rsp_addr_q, rsp_addr_d;
    logic [DATA_W-1:0] rsp_dat_q,  rsp_dat_d;

    logic [DATA_W-1:0] mem_q [MEM_WORDS];
    logic              mem_we;
    logic [IDX_W-1:0]  mem_idx;

    // ------------------------------------------------------------------
    // Ready / optional refresh windows
    // ------------------------------------------------------------------
`ifdef MEM_REFRESH_EN
    localparam int CNT_W = $clog2(REFRESH_PERIOD + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       refresh_q, refresh_d;   // refresh cycles still to run, including the current one

    always_comb begin
        cnt_d     = cnt_q + CNT_W'(1);
        refresh_d = refresh_q;
        if (refresh_q != 2'd0) begin
            refresh_d = refresh_q - 2'd1;
            cnt_d     = '0;
        end else if (cnt_q == CNT_W'(REFRESH_PERIOD - 1)) begin
            refresh_d = 2'd2;
            cnt_d     = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            refresh_q <= 2'd0;
        end else begin
            cnt_q     <= cnt_d;
            refresh_q <= refresh_d;
        end
    end

    assign memReady = ready_q && (refresh_q == 2'd0);
`else
    assign memReady = ready_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Request pipeline (never stalls)
    // ------------------------------------------------------------------
    always_comb begin
        in_stage      = '0;
        in_stage.vld  = memEnable && memReady;
        in_stage.wr   = memWrite;
        in_stage.src  = reqSrc;
        in_stage.addr = addrToMem;
        in_stage.dat  = dataToMem;
    end

    always_comb begin
        pipe_d[0] = in_stage;
        for (int i = 1; i < DEPTH; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
        end
    end

    // Entry that retires at the coming edge; with LATENCY 1 it is the request itself.
    assign ret_stage = (LATENCY == 1) ? in_stage : pipe_q[DEPTH-1];

    // ------------------------------------------------------------------
    // Backing array: access happens at the retiring edge, so a write commits
    // strictly before any later-accepted read samples the same word.
    // ------------------------------------------------------------------
    assign mem_idx = ret_stage.addr[IDX_W-1:0];
    assign mem_we  = ret_stage.vld && ret_stage.wr;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_idx] <= ret_stage.dat;
        end
    end

    // ------------------------------------------------------------------
    // Response register: strobe every cycle, payload held between responses
    // ------------------------------------------------------------------
    always_comb begin
        rsp_vld_d  = ret_stage.vld;
        rsp_wr_d   = rsp_wr_q;
        rsp_src_d  = rsp_src_q;
        rsp_addr_d = rsp_addr_q;
        rsp_dat_d  = rsp_dat_q;
        if (ret_stage.vld) begin
            rsp_wr_d   = ret_stage.wr;
            rsp_src_d  = ret_stage.src;
            rsp_addr_d = ret_stage.addr;
            rsp_dat_d  = ret_stage.wr ? ret_stage.dat : mem_q[mem_idx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_vld_q  <= 1'b0;
            rsp_wr_q   <= 1'b0;
            rsp_src_q  <= 1'b0;
            rsp_addr_q <= '0;
            rsp_dat_q  <= '0;
        end else begin
            rsp_vld_q  <= rsp_vld_d;
            rsp_wr_q   <= rsp_wr_d;
            rsp_src_q  <= rsp_src_d;
            rsp_addr_q <= rsp_addr_d;
            rsp_dat_q  <= rsp_dat_d;
        end
    end

    assign rspValid    = rsp_vld_q;
    assign rspWrite    = rsp_wr_q;
    assign rspSrc      = rsp_src_q;
    assign rspAddr     = rsp_addr_q;
    assign dataFromMem = rsp_dat_q;

endmodule

// File: tb/tb_mem_pipe_ctrl.sv
// Directed bench for mem_pipe_ctrl (LATENCY 4, MEM_WORDS 1024).
// Inputs are driven and outputs sampled on the falling edge: each step() is one cycle.
// With MEM_REFRESH_EN the bench runs the refresh-window scenario with REFRESH_PERIOD 8.
module tb_mem_pipe_ctrl;

    logic        clk;
    logic        rst_n;
    logic        memEnable;
    logic        memWrite;
    logic        reqSrc;
    logic [15:0] addrToMem;
    logic [15:0] dataToMem;
    logic        memReady;
    logic        rspValid;
    logic        rspWrite;
    logic        rspSrc;
    logic [15:0] rspAddr;
    logic [15:0] dataFromMem;

    int checks   = 0;
    int failures = 0;

    int          k;
    logic        wr;
    logic [15:0] a;

    mem_pipe_ctrl #(
        .ADDR_W        (16),
        .DATA_W        (16),
        .MEM_WORDS     (1024),
        .LATENCY       (4)
`ifdef MEM_REFRESH_EN
        ,
        .REFRESH_PERIOD(8)
`endif
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .memEnable  (memEnable),
        .memWrite   (memWrite),
        .reqSrc     (reqSrc),
        .addrToMem  (addrToMem),
        .dataToMem  (dataToMem),
        .memReady   (memReady),
        .rspValid   (rspValid),
        .rspWrite   (rspWrite),
        .rspSrc     (rspSrc),
        .rspAddr    (rspAddr),
        .dataFromMem(dataFromMem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic en, input logic w, input logic src,
                        input logic [15:0] addr, input logic [15:0] dat);
        @(negedge clk);
        memEnable = en;
        memWrite  = w;
        reqSrc    = src;
        addrToMem = addr;
        dataToMem = dat;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    endtask

    task automatic rsp(input string tag, input logic w, input logic src,
                       input logic [15:0] addr, input logic [15:0] dat);
        chk({tag, "_vld"}, rspValid, 1);
        if (rspValid === 1'b1) begin
            chk({tag, "_wr"},   rspWrite, w);
            chk({tag, "_src"},  rspSrc, src);
            chk({tag, "_addr"}, rspAddr, addr);
            chk({tag, "_data"}, dataFromMem, dat);
        end
    endtask

    task automatic quiet(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            idle();
            chk(tag, rspValid, 0);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        memEnable = 1'b0;
        memWrite  = 1'b0;
        reqSrc    = 1'b0;
        addrToMem = 16'h0;
        dataToMem = 16'h0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ready", memReady, 0);
        chk("rst_vld",   rspValid, 0);
        chk("rst_data",  dataFromMem, 0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rel_ready_pre_edge", memReady, 0);

`ifdef MEM_REFRESH_EN
        // Cycle n is the falling edge after the n-th rising edge since release.
        for (int n = 1; n <= 25; n++) begin
            @(negedge clk);
            memEnable = ((n >= 8 && n <= 10) || (n >= 18 && n <= 20));
            memWrite  = 1'b0;
            reqSrc    = n[0];
            addrToMem = 16'(n);
            chk($sformatf("ref_ready_c%0d", n), memReady,
                (n == 8 || n == 9 || n == 18 || n == 19) ? 0 : 1);
            chk($sformatf("ref_vld_c%0d", n), rspValid, (n == 14 || n == 24) ? 1 : 0);
            if (n == 14) chk("ref_addr_c14", rspAddr, 16'd10);
            if (n == 24) chk("ref_addr_c24", rspAddr, 16'd20);
        end
`else
        // Idle after release: ready from the first edge, outputs stay zero
        for (int i = 0; i < 10; i++) begin
            idle();
            chk("idle_ready", memReady, 1);
            chk("idle_vld",   rspValid, 0);
            chk("idle_wr",    rspWrite, 0);
            chk("idle_src",   rspSrc, 0);
            chk("idle_addr",  rspAddr, 0);
            chk("idle_data",  dataFromMem, 0);
        end

        // Preload 0xBEEF at 0x0010, then read it back (response exactly 4 cycles later)
        step(1, 1, 1, 16'h0010, 16'hBEEF);
        quiet("pre_gap", 3);
        idle();
        rsp("pre_ack", 1, 1, 16'h0010, 16'hBEEF);
        step(1, 0, 1, 16'h0010, 16'h0);
        chk("rd_gap0", rspValid, 0);
        quiet("rd_gap", 3);
        idle();
        rsp("rd", 0, 1, 16'h0010, 16'hBEEF);
        quiet("rd_after", 2);

        // Write then read same address on consecutive cycles
        step(1, 1, 0, 16'h0020, 16'h1234);
        step(1, 0, 1, 16'h0020, 16'h0);
        chk("raw_gap0", rspValid, 0);
        quiet("raw_gap", 2);
        idle();
        rsp("raw_ack", 1, 0, 16'h0020, 16'h1234);
        idle();
        rsp("raw_rd", 0, 1, 16'h0020, 16'h1234);
        quiet("raw_after", 1);

        // Four writes then four back-to-back reads (srcs 0,1,0,1, addrs 1..4)
        for (int t = 0; t < 13; t++) begin
            if (t < 8) begin
                k  = t;
                wr = (k < 4);
                a  = wr ? 16'(k + 1) : 16'(k - 3);
                step(1, wr, k[0], a, 16'hA000 + a);
            end else begin
                idle();
            end
            if (t >= 4 && t < 12) begin
                k  = t - 4;
                wr = (k < 4);
                a  = wr ? 16'(k + 1) : 16'(k - 3);
                rsp($sformatf("b2b%0d", k), wr, k[0], a, 16'hA000 + a);
            end else begin
                chk($sformatf("b2b_idle%0d", t), rspValid, 0);
            end
        end

        // Address aliasing: 0x0405 and 0x0005 share a word
        step(1, 1, 0, 16'h0405, 16'hAAAA);
        step(1, 0, 1, 16'h0005, 16'h0);
        quiet("alias_gap", 2);
        idle();
        rsp("alias_ack", 1, 0, 16'h0405, 16'hAAAA);
        idle();
        rsp("alias_rd", 0, 1, 16'h0005, 16'hAAAA);

        // Reset mid-operation: committed write survives, in-flight work is dropped
        step(1, 1, 0, 16'h0030, 16'h1111);
        quiet("mid_pre_gap", 3);
        idle();
        rsp("mid_pre_ack", 1, 0, 16'h0030, 16'h1111);
        step(1, 0, 0, 16'h0010, 16'h0);
        step(1, 0, 1, 16'h0020, 16'h0);
        step(1, 1, 1, 16'h0030, 16'h5555);
        @(negedge clk);
        rst_n     = 1'b0;
        memEnable = 1'b0;
        #1;
        chk("mid_rst_ready", memReady, 0);
        chk("mid_rst_vld",   rspValid, 0);
        chk("mid_rst_addr",  rspAddr, 0);
        chk("mid_rst_data",  dataFromMem, 0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("mid_rel_ready", memReady, 0);
        quiet("mid_flush", 8);
        chk("mid_ready_back", memReady, 1);
        step(1, 0, 0, 16'h0030, 16'h0);
        quiet("mid_rd_gap", 3);
        idle();
        rsp("mid_rd", 0, 0, 16'h0030, 16'h1111);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_pipe_ctrl.md
Name: mem_pipe_ctrl

Overview:
- Main-memory controller directly downstream of the I/D-cache memory arbiter.
- Consumes the arbiter's single granted request: address, write data and memory enable, plus the write flag and requester id.
- Services each request with a fixed, fully pipelined latency; one new request per cycle.
- Returns response data tagged with the requester id so the caches can route it.

Parameters:
ADDR_W, 16, address width (matches arbiter address bus)
DATA_W, 16, data word width (matches arbiter data bus)
MEM_WORDS, 1024, words in backing array; power of two, at most 2^ADDR_W
LATENCY, 4, cycles from acceptance cycle to response cycle; legal range 1..16

Ports:
clk  in  1  system clock; all state updates on rising edge
rst_n  in  1  reset, asynchronous assert, active-low
memEnable  in  1  request valid from arbiter
memWrite  in  1  1 = write, 0 = read
reqSrc  in  1  requester id: 0 = ICache, 1 = DCache
addrToMem  in  ADDR_W  request word address
dataToMem  in  DATA_W  write data; ignored for reads
memReady  out  1  controller can accept a request this cycle
rspValid  out  1  one-cycle response strobe
rspWrite  out  1  response belongs to a write (write acknowledge)
rspSrc  out  1  requester id of the response
rspAddr  out  ADDR_W  address of the response
dataFromMem  out  DATA_W  read data, or the echoed write data for writes

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset (rst_n = 0):
  - All pipeline valid bits are cleared immediately.
  - rspValid, rspWrite, rspSrc, rspAddr and dataFromMem are 0; memReady is 0.
  - The backing array is not reset.
- After reset release, memReady goes 1 from the first rising edge.
- Acceptance: a request is accepted in cycle c when memEnable = 1 and memReady = 1 are both high in that cycle.
  - When memReady = 0, the requester holds its request; nothing is captured or lost.
- Pipeline:
  - A LATENCY-deep shift pipeline carries valid, write, src, addr and data.
  - No stalls occur inside the pipeline; every accepted request retires exactly LATENCY cycles later.
  - Throughput is one request per cycle, with up to LATENCY requests in flight.
- Response:
  - rspValid = 1 for exactly the single cycle c+LATENCY, with rspSrc, rspAddr and rspWrite from the request.
  - Read: dataFromMem = array contents sampled at the edge beginning cycle c+LATENCY.
  - Write: the array is updated at the edge beginning cycle c+LATENCY; dataFromMem echoes the written data.
  - Responses return in request order.
- Outputs outside response cycles: rspValid = 0. Other response outputs hold their last value; the bench must not check them.
- Ordering: a read accepted in any cycle after a write to the same address returns the new data, because writes commit one or more edges before that read samples. At most one access retires per edge, so there are no read/write collisions.
- Addressing: array index = addrToMem[log2(MEM_WORDS)-1:0]; upper bits alias (wrap-around). rspAddr reports the full unmodified address.
- Reset mid-operation:
  - All in-flight requests are discarded and no responses are produced for them.
  - Writes not yet committed are lost; writes already committed are retained.
- LATENCY = 1: a request accepted in cycle c responds in cycle c+1.

Optional Feature:
- Macro: MEM_REFRESH_EN.
- Defined:
  - Parameter REFRESH_PERIOD (default 64) applies. A free-running counter, reset to 0, counts cycles.
  - When the counter reaches REFRESH_PERIOD-1, the next 2 cycles are refresh cycles and the counter restarts at 0 after them.
  - memReady = 0 during refresh cycles, so no new requests are accepted.
  - In-flight requests keep advancing and retire on schedule.
- Undefined: no counter exists; memReady = 1 in every cycle after reset release.

Test Plan:
- Reset, then idle 10 cycles -> memReady = 1 from the first edge after release; rspValid stays 0; all response outputs 0 until the first response.
- Read accepted in cycle 5, addr 0x0010, src 1, array[0x10] preloaded 0xBEEF -> rspValid only in cycle 9, dataFromMem 0xBEEF, rspSrc 1, rspWrite 0.
- Write 0x1234 to 0x0020 in cycle 3, read 0x0020 in cycle 4 -> write ack in cycle 7 echoing 0x1234; read response in cycle 8 returns 0x1234.
- Four back-to-back reads, srcs 0,1,0,1, addrs 0x1..0x4 -> rspValid high in cycles c+4..c+7 in order with matching srcs and addrs.
- Write 0xAAAA to 0x0405 (MEM_WORDS 1024), then read 0x0005 -> 0xAAAA; rspAddr 0x0005.
- rst_n pulsed low 1 cycle after two reads accepted -> no rspValid for them; with MEM_REFRESH_EN and REFRESH_PERIOD 8, memReady low in cycles 8-9, 18-19, and held requests accepted in cycles 10 and 20.
